imem_fetch_arbiter: RTL

Shares one single-port, synchronous-read instruction memory between the two cores of the multi-core CPU. Each core issues word-addressed fetch requests through a req/gnt handshake. The block grants one request per cycle using round-robin, drives the memory port, and returns the fetched word to the owning core with a registered valid pulse. It also keeps per-core saturating fetch counters for performance debug.

---
 rtl/imem_fetch_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction memory between two cores.
// Fixed two-cycle grant-to-rvalid pipeline with per-core saturating fetch counters.
module imem_fetch_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  mem_en,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [CNT_W-1:0]      fetch_cnt0,
    output logic [CNT_W-1:0]      fetch_cnt1
);

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_t;

    typedef struct packed {
        logic vld;
        logic id;
        logic err;
    } inflight_t;

    last_t             last_q;
    last_t             last_d;
    inflight_t         infl_q;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              in_range;

    // Priority state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= LAST1;
        end else begin
            last_q <= last_d;
        end
    end

    // Round-robin grant; core 0 wins a tie unless it was granted last
    always_comb begin
        last_d = last_q;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (reset) begin
            if (req0 && (!req1 || (last_q == LAST1))) begin
                gnt0   = 1'b1;
                last_d = LAST0;
            end else if (req1) begin
                gnt1   = 1'b1;
                last_d = LAST1;
            end
        end
    end

    // Memory port drive for the granted core
    always_comb begin
        grant    = gnt0 | gnt1;
        sel_addr = gnt1 ? addr1 : addr0;
        in_range = (sel_addr[ADDR_W-1:DEPTH_LOG2] == '0);
        mem_en   = grant && in_range;
        mem_addr = mem_en ? sel_addr[DEPTH_LOG2-1:0] : '0;
    end

    // In-flight tag for the access whose data arrives next cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            infl_q <= '0;
        end else begin
            infl_q.vld <= grant;
            infl_q.id  <= gnt1;
            infl_q.err <= grant && !in_range;
        end
    end

    // Completion registers and counters; counters advance with the rvalid pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            fetch_cnt0 <= '0;
            fetch_cnt1 <= '0;
        end else begin
            rvalid0 <= infl_q.vld && !infl_q.id;
            rvalid1 <= infl_q.vld && infl_q.id;
            if (infl_q.vld && !infl_q.id) begin
                rdata0 <= infl_q.err ? '0 : mem_rdata;
                err0   <= infl_q.err;
                if (fetch_cnt0 != '1) begin
                    fetch_cnt0 <= fetch_cnt0 + CNT_W'(1);
                end
            end
            if (infl_q.vld && infl_q.id) begin
                rdata1 <= infl_q.err ? '0 : mem_rdata;
                err1   <= infl_q.err;
                if (fetch_cnt1 != '1) begin
                    fetch_cnt1 <= fetch_cnt1 + CNT_W'(1);
                end
            end
        end
    end

endmodule
